// File: rtl/sha256_job_arbiter.sv
// -----------------------------------------------------------------------------
// sha256_job_arbiter
//
// Round-robin scheduler that shares a single simplified_sha256 core among
// NUM_REQ job sources. One requester is granted at a time. Its message and
// output addresses are latched on the grant edge and `core_start_o` is pulsed
// for one cycle. The arbiter then follows the core's idle level through busy
// and back to idle, and returns a one-hot completion pulse to the requester.
//
// Optional feature macro: SHA_ARB_WATCHDOG_EN
//   When defined, a watchdog aborts a job that exceeds TIMEOUT_CYCLES. The
//   abort is reported as a completion with resp_err_o=1. The core itself is
//   not touched, and the next grant still waits for core_done_i=1.
//   When undefined, resp_err_o is always 0 and the wait states never time out.
//
// Parameters
//   NUM_REQ         number of requesters (2..16)
//   TIMEOUT_CYCLES  watchdog limit in cycles (watchdog builds only)
//
// Ports
//   clk                  clock
//   reset                synchronous, active-high reset
//   req_i                level request per requester, held until its response
//   req_msg_addr_i       per-requester message word address (16b each)
//   req_out_addr_i       per-requester output word address (16b each)
//   resp_valid_o         one-cycle, one-hot completion pulse
//   resp_err_o           qualifies resp_valid_o: job aborted by the watchdog
//   core_start_o         one-cycle start pulse to the hash core
//   core_message_addr_o  latched message address (held between jobs)
//   core_output_addr_o   latched output address (held between jobs)
//   core_done_i          core idle level
//   busy_o               high in every state except IDLE
//   grant_id_o           index of the current or most recent grant
//
// All outputs are registered. They are decoded from the next state, so no
// combinational path runs from any input to any output.
// -----------------------------------------------------------------------------
module sha256_job_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ-1:0][15:0]       req_msg_addr_i,
    input  logic [NUM_REQ-1:0][15:0]       req_out_addr_i,
    output logic [NUM_REQ-1:0]             resp_valid_o,
    output logic                           resp_err_o,
    output logic                           core_start_o,
    output logic [15:0]                    core_message_addr_o,
    output logic [15:0]                    core_output_addr_o,
    input  logic                           core_done_i,
    output logic                           busy_o,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id_o
);

    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESP
    } state_e;

    typedef struct packed {
        logic [15:0] msg;
        logic [15:0] out;
    } job_t;

    state_e               state_q, state_d;
    job_t                 job_q, job_d;
    logic [IDW-1:0]       grant_id_q, grant_id_d;
    logic [IDW-1:0]       last_q, last_d;
    logic                 core_start_q, core_start_d;
    logic                 busy_q, busy_d;
    logic                 resp_err_q, resp_err_d;
    logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;

    logic                 pick_vld;
    logic [IDW-1:0]       pick_id;
    logic                 wd_expire;

    // (base + k) mod NUM_REQ, for 1 <= k <= NUM_REQ. NUM_REQ may be a
    // non-power-of-two, so the wrap is a single subtraction.
    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDW'(s);
    endfunction

    // Round-robin pick. The scan runs from the farthest slot to the nearest,
    // so the first set bit after `last` overwrites every other candidate.
    // The farthest slot (k=NUM_REQ) is `last` itself, which makes a requester
    // that is still asserting after its response the lowest priority.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_i[rr_idx(last_q, k)]) begin
                pick_vld = 1'b1;
                pick_id  = rr_idx(last_q, k);
            end
        end
    end

`ifdef SHA_ARB_WATCHDOG_EN
    logic [31:0] wd_cnt_q;

    // Cleared on the grant edge (entry to ISSUE). Counts every cycle spent
    // waiting on the core.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_q <= '0;
        end else if (state_d == S_ISSUE) begin
            wd_cnt_q <= '0;
        end else if (state_q == S_WAIT_BUSY || state_q == S_WAIT_DONE) begin
            wd_cnt_q <= wd_cnt_q + 32'd1;
        end
    end

    // Expire on the edge where the counter reaches TIMEOUT_CYCLES-1. The
    // abort response then lands exactly TIMEOUT_CYCLES cycles after start.
    assign wd_expire = (state_q == S_WAIT_BUSY || state_q == S_WAIT_DONE) &&
                       ((wd_cnt_q + 32'd1) == 32'(TIMEOUT_CYCLES - 1));
`else
    assign wd_expire = 1'b0;
`endif

    // State register, together with the registered outputs and job context.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            job_q        <= '0;
            grant_id_q   <= '0;
            last_q       <= IDW'(NUM_REQ - 1);
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            job_q        <= job_d;
            grant_id_q   <= grant_id_d;
            last_q       <= last_d;
            core_start_q <= core_start_d;
            busy_q       <= busy_d;
            resp_err_q   <= resp_err_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                // An idle core is required even after a watchdog abort or a
                // mid-job reset, because the core may still be running.
                if (core_done_i && pick_vld) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (wd_expire)         state_d = S_RESP;
                else if (!core_done_i) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (wd_expire || core_done_i) state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output and context next values. These are decoded from state_d so that
    // each registered output is valid in the same cycle as its state.
    always_comb begin
        core_start_d = (state_d == S_ISSUE);
        busy_d       = (state_d != S_IDLE);
        resp_valid_d = '0;
        resp_err_d   = 1'b0;
        grant_id_d   = grant_id_q;
        job_d        = job_q;
        last_d       = last_q;

        if (state_d == S_RESP) begin
            resp_valid_d[grant_id_q] = 1'b1;
            resp_err_d               = wd_expire;
        end

        // Addresses are sampled only on the grant edge.
        if (state_q == S_IDLE && state_d == S_ISSUE) begin
            grant_id_d = pick_id;
            job_d.msg  = req_msg_addr_i[pick_id];
            job_d.out  = req_out_addr_i[pick_id];
        end

        if (state_q == S_RESP) last_d = grant_id_q;
    end

    assign core_start_o        = core_start_q;
    assign busy_o              = busy_q;
    assign resp_valid_o        = resp_valid_q;
    assign resp_err_o          = resp_err_q;
    assign grant_id_o          = grant_id_q;
    assign core_message_addr_o = job_q.msg;
    assign core_output_addr_o  = job_q.out;

endmodule

// File: tb/tb_sha256_job_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sha256_job_arbiter
//
// Directed and random bench for sha256_job_arbiter with NUM_REQ=4 and
// TIMEOUT_CYCLES=16. A small behavioural hash-core model drops `done` after
// it samples start and raises it again after a programmable latency. It can
// also be held low or hung. The expected grant order comes from a plain
// round-robin model (first request after the last served index), and the
// expected response timing follows the arbiter's cycle rules.
// The watchdog scenario is compiled only when SHA_ARB_WATCHDOG_EN is defined.
// -----------------------------------------------------------------------------
module tb_sha256_job_arbiter;

    localparam int N = 4;

    logic                 clk   = 1'b0;
    logic                 reset = 1'b1;
    logic [N-1:0]         req   = '0;
    logic [N-1:0][15:0]   msg_a = '0;
    logic [N-1:0][15:0]   out_a = '0;
    logic [N-1:0]         resp_valid;
    logic                 resp_err;
    logic                 core_start;
    logic [15:0]          core_msg;
    logic [15:0]          core_out;
    logic                 core_done;
    logic                 busy;
    logic [1:0]           grant_id;

    // hash core model state
    logic core_idle      = 1'b1;
    logic core_hang      = 1'b0;
    logic core_force_low = 1'b0;
    int   core_cnt       = 0;
    int   core_lat       = 2;

    int errors = 0;
    int checks = 0;
    int last_m = N - 1;

    sha256_job_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
        .clk                 (clk),
        .reset               (reset),
        .req_i               (req),
        .req_msg_addr_i      (msg_a),
        .req_out_addr_i      (out_a),
        .resp_valid_o        (resp_valid),
        .resp_err_o          (resp_err),
        .core_start_o        (core_start),
        .core_message_addr_o (core_msg),
        .core_output_addr_o  (core_out),
        .core_done_i         (core_done),
        .busy_o              (busy),
        .grant_id_o          (grant_id)
    );

    always #5 clk = ~clk;

    // Core model: leaves idle on a sampled start, then returns to idle after
    // core_lat+1 busy cycles unless it is hung.
    always @(posedge clk) begin
        if (core_idle) begin
            if (core_start) begin
                core_idle <= 1'b0;
                core_cnt  <= core_lat;
            end
        end else if (!core_hang) begin
            if (core_cnt == 0) core_idle <= 1'b1;
            else               core_cnt  <= core_cnt - 1;
        end
    end

    assign core_done = core_idle && !core_force_low;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Round-robin reference: first requester after `last`, wrapping around.
    function automatic int model_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return 0;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        last_m = N - 1;
    endtask

    task automatic wait_start(output int n);
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (core_start) begin
                n = i;
                break;
            end
        end
    endtask

    // Called at the negedge of the start cycle. The job runs to its response.
    task automatic finish_job(input int id, input logic [15:0] em, input logic [15:0] eo,
                              input bit mutate, input bit drop);
        logic [N-1:0] exp_v;
        bit seen_low, got, early;
        chk("grant_id", 32'(grant_id), 32'(id));
        chk("msg_at_start", 32'(core_msg), 32'(em));
        chk("out_at_start", 32'(core_out), 32'(eo));
        chk("busy_in_job", 32'(busy), 32'd1);
        if (mutate) msg_a[id] = 16'h0FFF;
        @(negedge clk);
        chk("start_width", 32'(core_start), 32'd0);
        seen_low = 1'b0;
        got      = 1'b0;
        early    = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (resp_valid != '0) early = 1'b1;
            if (!core_done) seen_low = 1'b1;
            else if (seen_low) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("done_return", 32'(got), 32'd1);
        chk("resp_early", 32'(early), 32'd0);
        // done is seen high this cycle, so the response comes in the next one
        @(negedge clk);
        exp_v     = '0;
        exp_v[id] = 1'b1;
        chk("resp_valid", 32'(resp_valid), 32'(exp_v));
        chk("resp_err_flag", 32'(resp_err), 32'd0);
        chk("msg_at_resp", 32'(core_msg), 32'(em));
        chk("out_at_resp", 32'(core_out), 32'(eo));
        if (drop) req[id] = 1'b0;
        last_m = id;
        @(negedge clk);
        chk("resp_width", 32'(resp_valid), 32'd0);
    endtask

    task automatic serve(input bit mutate, input bit drop, output int gid, output int n);
        int exp;
        logic [15:0] em, eo;
        exp = model_pick(req, last_m);
        em  = msg_a[exp];
        eo  = out_a[exp];
        wait_start(n);
        chk("start_seen", 32'(n > 0), 32'd1);
        gid = -1;
        if (n > 0) begin
            gid = int'(grant_id);
            finish_job(exp, em, eo, mutate, drop);
        end
    endtask

    initial begin
        int  gid, n, d_cyc, s_cyc;
        bit  saw, rv;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(core_start), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_msg", 32'(core_msg), 32'd0);
        chk("rst_out", 32'(core_out), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        reset  = 1'b0;
        last_m = N - 1;

        // single request
        msg_a[1] = 16'h0100;
        out_a[1] = 16'h0200;
        core_lat = 3;
        req      = 4'b0010;
        serve(0, 1, gid, n);
        chk("single_latency", 32'(n), 32'd1);
        chk("single_gid", 32'(gid), 32'd1);
        chk("single_msg", 32'(core_msg), 32'h0100);
        chk("single_out", 32'(core_out), 32'h0200);

        // fairness from reset: 0,1,2,3 with back-to-back 2-cycle gaps
        do_reset();
        for (int k = 0; k < N; k++) begin
            msg_a[k] = 16'($urandom);
            out_a[k] = 16'($urandom);
        end
        core_lat = 1;
        req      = 4'b1111;
        for (int i = 0; i < N; i++) begin
            serve(0, 1, gid, n);
            chk("fair_order", 32'(gid), 32'(i));
            chk("b2b_gap", 32'(n), 32'd1);
        end
        req = 4'b1001;
        serve(0, 1, gid, n);
        chk("fair_1001_a", 32'(gid), 32'd0);
        serve(0, 1, gid, n);
        chk("fair_1001_b", 32'(gid), 32'd3);

        // holding req after the response puts the requester at lowest priority
        req = 4'b0011;
        serve(0, 0, gid, n);
        chk("rearb_a", 32'(gid), 32'd0);
        serve(0, 0, gid, n);
        chk("rearb_b", 32'(gid), 32'd1);
        serve(0, 1, gid, n);
        chk("rearb_c", 32'(gid), 32'd0);
        req = '0;
        repeat (2) @(negedge clk);

        // core busy at request time
        core_force_low = 1'b1;
        req            = 4'b0001;
        saw            = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (core_start) saw = 1'b1;
        end
        chk("no_start_core_busy", 32'(saw), 32'd0);
        @(posedge clk);
        #1 core_force_low = 1'b0;
        @(negedge clk);
        chk("start_not_same_cycle", 32'(core_start), 32'd0);
        serve(0, 1, gid, n);
        chk("start_after_done", 32'(n), 32'd1);
        chk("busy_core_gid", 32'(gid), 32'd0);

        // address change one cycle after grant is ignored
        msg_a[0] = 16'h0010;
        out_a[0] = 16'h0A0A;
        req      = 4'b0001;
        serve(1, 1, gid, n);
        chk("addr_hold_msg", 32'(core_msg), 32'h0010);

        // reset while in WAIT_DONE
        core_lat = 8;
        msg_a[0] = 16'h1234;
        req      = 4'b0001;
        wait_start(n);
        chk("rj_start_seen", 32'(n > 0), 32'd1);
        @(negedge clk);
        chk("rj_core_busy", 32'(core_done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rj_busy", 32'(busy), 32'd0);
        chk("rj_resp", 32'(resp_valid), 32'd0);
        reset    = 1'b0;
        last_m   = N - 1;
        core_lat = 2;
        d_cyc    = -1;
        s_cyc    = -1;
        rv       = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (resp_valid != '0) rv = 1'b1;
            if (core_start) begin
                s_cyc = i;
                break;
            end
            if (core_done && d_cyc < 0) d_cyc = i;
        end
        chk("rj_no_resp", 32'(rv), 32'd0);
        chk("rj_regrant_seen", 32'(s_cyc > 0), 32'd1);
        chk("rj_grant_waits_done", 32'(s_cyc), 32'(d_cyc + 1));
        if (s_cyc > 0) finish_job(0, msg_a[0], out_a[0], 0, 1);

        // random traffic against the round-robin model
        for (int it = 0; it < 16; it++) begin
            core_lat = $urandom_range(0, 5);
            for (int k = 0; k < N; k++) begin
                msg_a[k] = 16'($urandom);
                out_a[k] = 16'($urandom);
            end
            if (req == '0) req = 4'($urandom_range(1, 15));
            serve(0, 1'($urandom_range(0, 1)), gid, n);
            chk("rand_gap", 32'(n), 32'd1);
            if ($urandom_range(0, 2) == 0) req = req | 4'($urandom_range(0, 15));
        end
        req = '0;
        repeat (3) @(negedge clk);
        chk("idle_after_rand", 32'(busy), 32'd0);

`ifdef SHA_ARB_WATCHDOG_EN
        // hung core: abort response 16 cycles after start
        core_hang = 1'b1;
        msg_a[0]  = 16'h00AA;
        req       = 4'b0001;
        wait_start(n);
        chk("wd_start_seen", 32'(n > 0), 32'd1);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (resp_valid != '0) begin
                n = i;
                break;
            end
        end
        chk("wd_latency", 32'(n), 32'd16);
        chk("wd_resp_valid", 32'(resp_valid), 32'b0001);
        chk("wd_resp_err", 32'(resp_err), 32'd1);
        last_m = 0;
        req    = 4'b0010;
        saw    = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (core_start) saw = 1'b1;
        end
        chk("wd_blocks_grant", 32'(saw), 32'd0);
        core_hang = 1'b0;
        wait_start(n);
        chk("wd_regrant_seen", 32'(n > 0), 32'd1);
        if (n > 0) finish_job(1, msg_a[1], out_a[1], 0, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
